rpn_display: RTL and testbench

RPN_DISPLAY -- requirements
Module: rpn_display

---
 rtl/rpn_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/rpn_display.sv | 132 +++++++++++++
 tb/tb_rpn_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator display path: seven-segment
// glyphs (active-low, bit order gfedcba), the display FSM states and the
// double-dabble nibble correction.
package rpn_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_SHOW  = 2'd3
    } rpn_state_t;

    // Double-dabble correction: a BCD nibble of 5 or more overflows past 9
    // after the next shift unless 3 is added first.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes go dark.
module seg7_decode
    import rpn_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup from digit value to glyph.
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/rpn_display.sv
// Converts the 8-bit stack-top word to decimal with a sequential
// double-dabble (one bit per clock) and shows it on four seven-segment
// digits: HEX3 sign, HEX2..HEX0 hundreds/tens/units, or "Err".
//
// Handshake: start is a one-cycle request, taken only while idle (busy low);
// value/is_signed/error are captured on that same edge. busy stays high until
// the cycle in which done pulses, and the HEX outputs change only in that
// cycle. A start while busy is dropped without a trace.
module rpn_display
    import rpn_pkg::*;
#(
    parameter bit BLANK_ZEROS = 1'b1,
    parameter int CONV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    input  logic       is_signed,
    input  logic       error,
    output logic       busy,
    output logic       done,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output rpn_state_t state_dbg
);

    localparam logic [3:0] LAST_ITER = 4'(CONV_CYCLES - 1);

    rpn_state_t  state_q, state_d;
    logic [7:0]  val_q;
    logic        sgn_q;
    logic        err_q;
    logic [7:0]  mag_q;
    logic [11:0] bcd_q;
    logic        neg_q;
    logic [3:0]  cnt_q;

    logic [7:0]  neg_mag;
    logic [11:0] bcd_adj;
    logic [6:0]  seg_h, seg_t, seg_u;
    logic        blank_h, blank_t;

    // Two's-complement negation; for inputs with bit 7 set the result
    // (256 - value) is at most 128, so eight bits always hold it.
    assign neg_mag = ~val_q + 8'd1;
    assign bcd_adj = {dd_adj(bcd_q[11:8]), dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};
    assign blank_h = BLANK_ZEROS && (bcd_q[11:8] == 4'd0);
    assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);

    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    seg7_decode u_dec_h (.bcd(bcd_q[11:8]), .seg(seg_h));
    seg7_decode u_dec_t (.bcd(bcd_q[7:4]),  .seg(seg_t));
    seg7_decode u_dec_u (.bcd(bcd_q[3:0]),  .seg(seg_u));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; an error request skips the conversion entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = error ? ST_SHOW : ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_ITER) state_d = ST_SHOW;
            ST_SHOW:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture, conversion datapath and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= 8'd0;
            sgn_q <= 1'b0;
            err_q <= 1'b0;
            mag_q <= 8'd0;
            bcd_q <= 12'd0;
            neg_q <= 1'b0;
            cnt_q <= 4'd0;
            done  <= 1'b0;
            HEX0  <= SEG_0;
            HEX1  <= SEG_OFF;
            HEX2  <= SEG_OFF;
            HEX3  <= SEG_OFF;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        val_q <= value;
                        sgn_q <= is_signed;
                        err_q <= error;
                    end
                end
                ST_LOAD: begin
                    mag_q <= (sgn_q && val_q[7]) ? neg_mag : val_q;
                    neg_q <= sgn_q && val_q[7];
                    bcd_q <= 12'd0;
                    cnt_q <= 4'd0;
                end
                ST_SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q + 4'd1;
                end
                ST_SHOW: begin
                    done <= 1'b1;
                    if (err_q) begin
                        HEX3 <= SEG_OFF;
                        HEX2 <= SEG_E;
                        HEX1 <= SEG_R;
                        HEX0 <= SEG_R;
                    end else begin
                        HEX3 <= neg_q ? SEG_MINUS : SEG_OFF;
                        HEX2 <= blank_h ? SEG_OFF : seg_h;
                        HEX1 <= blank_t ? SEG_OFF : seg_t;
                        HEX0 <= seg_u;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_display.sv
// Directed bench for rpn_display: number formatting, sign, blanking, error
// display, latency, ignored starts and reset behaviour.
module tb_rpn_display;

    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_4   = 7'b0011001;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_7   = 7'b1111000;
    localparam logic [6:0] S_8   = 7'b0000000;
    localparam logic [6:0] S_E   = 7'b0000110;
    localparam logic [6:0] S_R   = 7'b0101111;
    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_MIN = 7'b0111111;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] value;
    logic       is_signed;
    logic       error;
    logic       busy;
    logic       done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    rpn_pkg::rpn_state_t state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    rpn_display #(.BLANK_ZEROS(1'b1), .CONV_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .is_signed (is_signed),
        .error     (error),
        .busy      (busy),
        .done      (done),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .state_dbg (state_dbg)
    );

    // Clock and safety net.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Driver: pulses start for one cycle and follows the conversion to done.
    // lat counts negedges after the start cycle (done expected in cycle N+lat).
    task automatic run_conv(input logic [7:0] v, input logic s, input logic e,
                            output int lat, output logic [27:0] hex, output int bad_hold,
                            output logic busy_at_done, output logic extra_done);
        logic [27:0] prev;
        @(negedge clk);
        prev = {HEX3, HEX2, HEX1, HEX0};
        value = v; is_signed = s; error = e; start = 1'b1;
        lat = -1; hex = 'x; bad_hold = 0; busy_at_done = 1'bx; extra_done = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                hex = {HEX3, HEX2, HEX1, HEX0};
                busy_at_done = busy;
                break;
            end
            if (busy !== 1'b1 || {HEX3, HEX2, HEX1, HEX0} !== prev) bad_hold++;
        end
        @(negedge clk);
        extra_done = done;
        error = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; value = 8'h00; is_signed = 1'b0; error = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {S_OFF, S_OFF, S_OFF, S_0}) begin
            n_fail++;
            $display("FAIL reset_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, {S_OFF, S_OFF, S_OFF, S_0});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_unsigned;
        logic [7:0]  vals [3] = '{8'hFF, 8'h80, 8'h0A};
        logic [27:0] exps [3] = '{{S_OFF, S_2, S_5, S_5}, {S_OFF, S_1, S_2, S_8}, {S_OFF, S_OFF, S_1, S_0}};
        int lat, bad; logic [27:0] hex; logic bz, xd;
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], 1'b0, 1'b0, lat, hex, bad, bz, xd);
            n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL unsigned_latency[%0d]: got %0d expected 11", i, lat); end
            n_checks++; if (hex !== exps[i]) begin n_fail++; $display("FAIL unsigned_hex[%0d]: got %h expected %h", i, hex, exps[i]); end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL unsigned_hold[%0d]: got %0d bad cycles expected 0", i, bad); end
            n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL unsigned_busy_at_done[%0d]: got %b expected 0", i, bz); end
            n_checks++; if (xd !== 1'b0) begin n_fail++; $display("FAIL unsigned_done_width[%0d]: got %b expected 0", i, xd); end
        end
    endtask

    task automatic test_signed;
        logic [7:0]  vals [3] = '{8'h80, 8'hFF, 8'h7F};
        logic [27:0] exps [3] = '{{S_MIN, S_1, S_2, S_8}, {S_MIN, S_OFF, S_OFF, S_1}, {S_OFF, S_1, S_2, S_7}};
        int lat, bad; logic [27:0] hex; logic bz, xd;
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], 1'b1, 1'b0, lat, hex, bad, bz, xd);
            n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected 11", i, lat); end
            n_checks++; if (hex !== exps[i]) begin n_fail++; $display("FAIL signed_hex[%0d]: got %h expected %h", i, hex, exps[i]); end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL signed_hold[%0d]: got %0d bad cycles expected 0", i, bad); end
        end
    endtask

    task automatic test_blanking;
        logic [7:0]  vals [2] = '{8'h07, 8'h00};
        logic [27:0] exps [2] = '{{S_OFF, S_OFF, S_OFF, S_7}, {S_OFF, S_OFF, S_OFF, S_0}};
        int lat, bad; logic [27:0] hex; logic bz, xd;
        for (int i = 0; i < 2; i++) begin
            run_conv(vals[i], 1'b0, 1'b0, lat, hex, bad, bz, xd);
            n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL blank_latency[%0d]: got %0d expected 11", i, lat); end
            n_checks++; if (hex !== exps[i]) begin n_fail++; $display("FAIL blank_hex[%0d]: got %h expected %h", i, hex, exps[i]); end
        end
    endtask

    task automatic test_error;
        int lat, bad; logic [27:0] hex; logic bz, xd;
        run_conv(8'h55, 1'b0, 1'b1, lat, hex, bad, bz, xd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL error_latency: got %0d expected 2", lat); end
        n_checks++;
        if (hex !== {S_OFF, S_E, S_R, S_R}) begin
            n_fail++; $display("FAIL error_hex: got %h expected %h", hex, {S_OFF, S_E, S_R, S_R});
        end
        n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL error_busy_at_done: got %b expected 0", bz); end
        n_checks++; if (xd !== 1'b0) begin n_fail++; $display("FAIL error_done_width: got %b expected 0", xd); end
        run_conv(8'h2A, 1'b0, 1'b0, lat, hex, bad, bz, xd);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL after_error_latency: got %0d expected 11", lat); end
        n_checks++;
        if (hex !== {S_OFF, S_OFF, S_4, S_2}) begin
            n_fail++; $display("FAIL after_error_hex: got %h expected %h", hex, {S_OFF, S_OFF, S_4, S_2});
        end
    endtask

    task automatic test_back_to_back;
        int first_done, n_done; logic [27:0] hex;
        @(negedge clk);
        value = 8'h64; is_signed = 1'b0; error = 1'b0; start = 1'b1;
        first_done = -1; n_done = 0; hex = 'x;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) begin first_done = k; hex = {HEX3, HEX2, HEX1, HEX0}; end
            end
            if (k == 4) begin start = 1'b1; value = 8'h01; end
        end
        n_checks++; if (first_done !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 11", first_done); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", n_done); end
        n_checks++;
        if (hex !== {S_OFF, S_1, S_0, S_0}) begin
            n_fail++; $display("FAIL b2b_hex: got %h expected %h", hex, {S_OFF, S_1, S_0, S_0});
        end
    endtask

    task automatic test_reset_abort;
        int n_done, lat, bad; logic [27:0] hex; logic bz, xd;
        @(negedge clk);
        value = 8'h55; is_signed = 1'b0; error = 1'b0; start = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start = 1'b0;
            reset = 1'b0;
            if (done) n_done++;
            if (k == 5) reset = 1'b1;
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d expected 0", n_done); end
        n_checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {S_OFF, S_OFF, S_OFF, S_0}) begin
            n_fail++;
            $display("FAIL abort_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, {S_OFF, S_OFF, S_OFF, S_0});
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end

        // Reset and start in the same cycle: reset must win.
        reset = 1'b1; start = 1'b1; value = 8'h33;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority_busy: got %b expected 0", busy); end
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL reset_priority_done: got %0d expected 0", n_done); end

        run_conv(8'h96, 1'b0, 1'b0, lat, hex, bad, bz, xd);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 11", lat); end
        n_checks++;
        if (hex !== {S_OFF, S_1, S_5, S_0}) begin
            n_fail++; $display("FAIL post_reset_hex: got %h expected %h", hex, {S_OFF, S_1, S_5, S_0});
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_blanking();
        test_error();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
